// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encoding and round-robin pick helper
// shared by the uart_tx_arbiter slice.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    LOCK
  } state_t;

  // Returns {hit, idx}: first set bit at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic       hit;
    logic [2:0] idx;
    int         k;
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (!hit && i < n && valid[k[2:0]]) begin
        hit = 1'b1;
        idx = k[2:0];
      end
    end
    return {hit, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin select,
// (valid, ptr) -> one-hot grant, index and any-valid flag.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  logic [MAX_REQ-1:0] v_ext;
  logic [3:0]         pick;

  always_comb begin
    v_ext = '0;
    v_ext[N_REQ-1:0] = valid;
    pick = rr_pick(v_ext, 3'(ptr), N_REQ);
    any = pick[3];
    idx = IW'(pick[2:0]);
    grant = '0;
    if (pick[3]) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART Avalon write port.
// Define UART_ARB_LOCK_EN to hold the grant until a packet's last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int BYTESIZE = 8,
  parameter int ADW      = 32,
  parameter int LOCK_TMO = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BYTESIZE-1:0] req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      uart_write,
  output logic [ADW-1:0]            uart_writedata,
  input  logic                      uart_waitreq,
  output logic [$clog2(N_REQ)-1:0]  grant_idx,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    arb_idx;
  logic [IW-1:0]    take_idx;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_any;
  logic             take;
  logic             done;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .valid(req_valid),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign done = uart_write & ~uart_waitreq;
  assign busy = (state_q != IDLE);

`ifdef UART_ARB_LOCK_EN
  localparam int TW = $clog2(LOCK_TMO + 2);
  localparam logic [TW-1:0] TMO_LD = TW'(LOCK_TMO);

  logic [TW-1:0] tmo_q;
  logic          last_q;
`else
  logic unused_lock;
  assign unused_lock = ^{req_last, (LOCK_TMO > 0)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    take      = 1'b0;
    take_idx  = grant_idx;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          take      = 1'b1;
          take_idx  = arb_idx;
          state_d   = WRITE;
        end
      end
`ifdef UART_ARB_LOCK_EN
      WRITE: begin
        if (done) state_d = last_q ? IDLE : LOCK;
      end
      LOCK: begin
        if (req_valid[grant_idx]) begin
          req_ready[grant_idx] = 1'b1;
          take    = 1'b1;
          state_d = WRITE;
        end else if (tmo_q == '0) begin
          state_d = IDLE;
        end
      end
`else
      WRITE: begin
        if (done) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      grant_idx      <= '0;
      uart_write     <= 1'b0;
      uart_writedata <= '0;
    end else begin
      if (take) begin
        grant_idx      <= take_idx;
        uart_writedata <= ADW'(req_data[int'(take_idx)*BYTESIZE +: BYTESIZE]);
        uart_write     <= 1'b1;
      end else if (done) begin
        uart_write <= 1'b0;
      end
      // pointer only moves on fresh arbitration, not on locked bytes
      if (take && state_q == IDLE)
        ptr_q <= (take_idx == LAST_IDX) ? '0 : take_idx + 1'b1;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      last_q <= 1'b1;
    end else begin
      if (take) last_q <= req_last[take_idx];
      if (state_q == WRITE && state_d == LOCK)
        tmo_q <= TMO_LD;
      else if (state_q == LOCK && tmo_q != '0)
        tmo_q <= tmo_q - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BS       = 8;
  localparam int ADW      = 32;
  localparam int IW       = 2;
  localparam int LOCK_TMO = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*BS-1:0] req_data = '0;
  logic [N-1:0]    req_last = '1;
  logic [N-1:0]    req_ready;
  logic            uart_write;
  logic [ADW-1:0]  uart_writedata;
  logic            uart_waitreq = 1'b0;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .BYTESIZE(BS),
    .ADW     (ADW),
    .LOCK_TMO(LOCK_TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_write    (uart_write),
    .uart_writedata(uart_writedata),
    .uart_waitreq  (uart_waitreq),
    .grant_idx     (grant_idx),
    .busy          (busy)
  );

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    req_last = '1;
    uart_waitreq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (uart_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_write got=%b exp=0", uart_write);
    end
    checks++;
    if (uart_writedata !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", uart_writedata);
    end
    checks++;
    if (busy !== 1'b0 || grant_idx !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b idx=%0d exp 0/0", busy, grant_idx);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[15:8] = 8'hA5;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (uart_write !== 1'b1 || uart_writedata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL single_write wr=%b data=%h exp 1/000000a5",
               uart_write, uart_writedata);
    end
    checks++;
    if (busy !== 1'b1 || grant_idx !== 2'd1 || req_ready !== '0) begin
      errors++;
      $display("FAIL single_state busy=%b idx=%0d rdy=%b exp 1/1/0000",
               busy, grant_idx, req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (uart_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop wr=%b busy=%b exp 0/0", uart_write, busy);
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[7:0] = 8'h3C;
    uart_waitreq = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_grant got=%b exp=0001", req_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      checks++;
      if (uart_write !== 1'b1 || uart_writedata !== 32'h3C || req_ready !== '0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d wr=%b data=%h rdy=%b exp 1/3c/0000",
                 i, uart_write, uart_writedata, req_ready);
      end
    end
    @(negedge clk);
    uart_waitreq = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (uart_write !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release wr=%b rdy=%b exp 0/0010", uart_write, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5A;
    uart_waitreq = 1'b1;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (uart_write !== 1'b1 || uart_writedata !== 32'h5A) begin
      errors++;
      $display("FAIL mid_pre wr=%b data=%h exp 1/5a", uart_write, uart_writedata);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (uart_write !== 1'b0 || busy !== 1'b0 || uart_writedata !== '0) begin
      errors++;
      $display("FAIL mid_async wr=%b busy=%b data=%h exp 0/0/0",
               uart_write, busy, uart_writedata);
    end
    @(negedge clk);
    rst = 1'b0;
    uart_waitreq = 1'b0;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_valid;
    int got[$];
    int cyc;
    int stall;
    int w;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*BS +: BS] = 8'h10 + 8'(i);
    cyc = 0;
    stall = 0;
    while (got.size() < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req_valid = '1;
      if (uart_write) begin
        uart_waitreq = (stall > 0);
        if (stall > 0) stall--;
      end else begin
        uart_waitreq = 1'b0;
        stall = $urandom_range(0, 4);
      end
      #1;
      if (uart_write && got.size() > 0) begin
        checks++;
        if (uart_writedata !== 32'(8'h10 + 8'(got[got.size()-1]))) begin
          errors++;
          $display("FAIL all_data got=%h exp=%h", uart_writedata,
                   8'h10 + 8'(got[got.size()-1]));
        end
      end
      if (req_ready !== '0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) w = k;
        checks++;
        if ($countones(req_ready) != 1) begin
          errors++;
          $display("FAIL all_onehot got=%b exp one bit", req_ready);
        end
        got.push_back(w);
      end
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL all_timeout got=%0d grants exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] != i % N) begin
          errors++;
          $display("FAIL all_order pos=%0d got=%0d exp=%0d", i, got[i], i % N);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_random;
    logic [7:0]   q[N][$];
    logic [N-1:0] exp_ready;
    logic [7:0]   cur;
    int ptr_m, phase, gw, w, left, cyc, n;
    do_reset();
    left = 0;
    for (int i = 0; i < N; i++) begin
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) q[i].push_back(8'($urandom));
      left += n;
    end
    ptr_m = 0;
    phase = 0;
    gw = 0;
    cur = '0;
    cyc = 0;
    while ((left > 0 || phase != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (q[i].size() > 0) && ($urandom_range(0, 3) != 0);
        req_data[i*BS +: BS] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
      end
      uart_waitreq = ($urandom_range(0, 2) == 0);
      #1;
      if (phase == 0) begin
        exp_ready = '0;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        if (w >= 0) exp_ready[w] = 1'b1;
        checks++;
        if (req_ready !== exp_ready || uart_write !== 1'b0) begin
          errors++;
          $display("FAIL rand_arb cyc=%0d rdy=%b exp=%b wr=%b exp=0",
                   cyc, req_ready, exp_ready, uart_write);
        end
        if (w >= 0) begin
          cur = q[w].pop_front();
          gw = w;
          ptr_m = (w + 1) % N;
          left--;
          phase = 1;
        end
      end else begin
        checks++;
        if (req_ready !== '0 || uart_write !== 1'b1 ||
            uart_writedata !== {24'h0, cur} || grant_idx !== IW'(gw)) begin
          errors++;
          $display("FAIL rand_write cyc=%0d rdy=%b wr=%b data=%h idx=%0d exp 0/1/%h/%0d",
                   cyc, req_ready, uart_write, uart_writedata, grant_idx, cur, gw);
        end
        if (!uart_waitreq) phase = 0;
      end
    end
    checks++;
    if (left != 0 || phase != 0) begin
      errors++;
      $display("FAIL rand_timeout left=%0d phase=%0d exp 0/0", left, phase);
    end
    req_valid = '0;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock;
    int got[$];
    int sent0, cyc;
    do_reset();
    sent0 = 0;
    cyc = 0;
    while (got.size() < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = {2'b00, 1'b1, (sent0 < 3)};
      req_data[7:0] = 8'hB0 + 8'(sent0);
      req_last = {3'b111, (sent0 == 2)};
      uart_waitreq = 1'($urandom_range(0, 1));
      #1;
      if (req_ready[0]) begin
        got.push_back(0);
        sent0++;
      end
      if (req_ready[1]) got.push_back(1);
    end
    checks++;
    if (got.size() != 4 || got[0] != 0 || got[1] != 0 || got[2] != 0 || got[3] != 1) begin
      errors++;
      $display("FAIL lock_order n=%0d seq=%p exp 0,0,0,1", got.size(), got);
    end
    req_valid = '0;
    uart_waitreq = 1'b0;
    repeat (4) @(negedge clk);
    req_valid = 4'b0001;
    req_last = 4'b1110;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lock_tmo_grant got=%b exp=0001", req_ready);
    end
    cyc = 0;
    while (cyc < LOCK_TMO + 50) begin
      @(negedge clk);
      cyc++;
      req_valid = 4'b0010;
      req_last = '1;
      #1;
      if (req_ready[1]) break;
    end
    checks++;
    if (cyc != LOCK_TMO + 3) begin
      errors++;
      $display("FAIL lock_tmo_release cyc=%0d exp=%0d", cyc, LOCK_TMO + 3);
    end
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_reset_mid();
    test_all_valid();
    test_random();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
